// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the SISO shift-chain controller.
package siso_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Shift cycles per transaction: data bits, optional parity bit, then chain flush.
   function automatic int calc_total(input int width, input int depth, input int p);
      return width + p + depth;
   endfunction

endpackage

// File: rtl/siso_shift_cnt.sv
// Loadable up-counter with terminal-count flag; saturates at TOTAL so it never wraps.
module siso_shift_cnt #(
   parameter  int TOTAL = 18,
   localparam int CW    = $clog2(TOTAL + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en && (count != CW'(TOTAL))) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == CW'(TOTAL - 1));

endmodule

// File: rtl/siso_shift_ctrl.sv
// Serialises a parallel word MSB-first through a SISO chain and captures it back.
// Optional even-parity bit and check enabled by defining SISO_CTRL_PARITY_EN.
module siso_shift_ctrl
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             sh_en,
   output logic             sh_in,
   input  logic             sh_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             perr
);

`ifdef SISO_CTRL_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int TOTAL = calc_total(WIDTH, DEPTH, P);
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int SW    = WIDTH + P;

   state_t          state, state_nxt;
   logic [SW-1:0]   tx, rx, tx_load;
   logic [CW-1:0]   k;
   logic            tc, accept, capture;

   assign accept  = in_valid && in_ready;
   assign capture = (state == SHIFT) && (k >= CW'(DEPTH));

   siso_shift_cnt #(.TOTAL(TOTAL)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .en    (state == SHIFT),
      .count (k),
      .tc    (tc)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = SHIFT;
         SHIFT:   if (tc)        state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      sh_en     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
         SHIFT:   sh_en     = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   // tx shifts left with zero fill, so its MSB yields data, parity, then flush zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx <= '0;
         rx <= '0;
      end else begin
         if (accept)               tx <= tx_load;
         else if (state == SHIFT)  tx <= {tx[SW-2:0], 1'b0};
         if (capture)              rx <= {rx[SW-2:0], sh_out};
      end
   end

   assign sh_in    = sh_en & tx[SW-1];
   assign out_data = rx[SW-1:P];

`ifdef SISO_CTRL_PARITY_EN
   assign tx_load = {in_data, ^in_data};
   // rx holds data plus received parity; any odd count of ones is a mismatch.
   assign perr    = out_valid & (^rx);
`else
   assign tx_load = in_data;
   assign perr    = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Self-checking bench for siso_shift_ctrl with behavioural SISO chains (DEPTH 6 and DEPTH 1).
// Parity cases are exercised when SISO_CTRL_PARITY_EN is defined.
module tb_siso_shift_ctrl;

   localparam int WIDTH = 12;
   localparam int DEPTH = 6;
`ifdef SISO_CTRL_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int TOTAL  = WIDTH + P + DEPTH;
   localparam int TOTAL1 = WIDTH + P + 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             perr;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] exp_data;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_ready, sh_en, sh_in, sh_out;
   logic             out_valid, out_ready, busy, perr;
   logic [WIDTH-1:0] in_data, out_data;

   logic             in_valid1, in_ready1, sh_en1, sh_in1, sh_out1;
   logic             out_valid1, out_ready1, busy1, perr1;
   logic [WIDTH-1:0] in_data1, out_data1;

   int               n_cmp = 0;
   int               n_err = 0;
   int               cyc = 0;
   int               acc_cyc = 0;
   int               en_k = 0;
   logic             prev_ov = 1'b0;
   exp_t             sb[$];
   logic             flip_on = 1'b0;
   int               flip_idx = 0;
   logic [DEPTH-1:0] chain0 = '0;
   logic             chain1 = 1'b0;
   vec_t             vecs[6];

   always #5 clk = ~clk;

   siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sh_en(sh_en), .sh_in(sh_in), .sh_out(sh_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .perr(perr)
   );

   siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .sh_en(sh_en1), .sh_in(sh_in1), .sh_out(sh_out1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1), .busy(busy1), .perr(perr1)
   );

   // Chain models: shift on sh_en, output is the last stage; en_k equals the controller's k.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_k <= sh_en ? en_k + 1 : 0;
   end
   always @(posedge clk) if (sh_en)  chain0 <= {chain0[DEPTH-2:0], sh_in};
   always @(posedge clk) if (sh_en1) chain1 <= sh_in1;
   assign sh_out  = chain0[DEPTH-1] ^ (flip_on && (en_k == DEPTH + flip_idx));
   assign sh_out1 = chain1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard consumer plus latency / shift-length checks on every delivered word.
   always @(negedge clk) begin
      if (out_valid && !prev_ov) begin
         check("latency", cyc - acc_cyc - 1, TOTAL);
         check("sh_en_cycles", en_k, TOTAL);
      end
      prev_ov <= out_valid;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            fail("unexpected_output");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("perr", perr, e.perr);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input exp_t e, output int acc);
      int n = 0;
      acc      = -1;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) begin
         sb.push_back(e);
         acc     = cyc;
         acc_cyc = cyc;
      end else begin
         fail("accept_timeout");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || busy) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   task automatic wait_ov();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail("out_valid_timeout");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, a1, a2, c, n;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

      vecs[0] = '{12'h000, 12'h000};
      vecs[1] = '{12'hFFF, 12'hFFF};
      vecs[2] = '{12'h5A3, 12'h5A3};
      vecs[3] = '{12'h801, 12'h801};
      vecs[4] = '{12'h7FE, 12'h7FE};
      vecs[5] = '{12'h124, 12'h124};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_sh_en", sh_en, 0);
      check("rst_sh_in", sh_in, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_perr", perr, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Single word with backpressure; in_valid/in_data during HOLD must be ignored
      send(12'hA5C, '{12'hA5C, 1'b0}, a0);
      wait_ov();
      in_valid = 1'b1;
      in_data  = 12'h111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_data", out_data, 12'hA5C);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);
      @(posedge clk); #1;

      // Table of echo vectors
      foreach (vecs[i]) begin
         send(vecs[i].data, '{vecs[i].exp_data, 1'b0}, a0);
         drain();
      end

      // Back-to-back: second accept exactly TOTAL+2 cycles after the first
      send(12'h3FF, '{12'h3FF, 1'b0}, a1);
      send(12'h400, '{12'h400, 1'b0}, a2);
      check("b2b_accept_gap", a2 - a1, TOTAL + 2);
      drain();

      // Reset asserted at k=7: outputs drop immediately, then a fresh word works
      send(12'hABC, '{12'hABC, 1'b0}, a0);
      repeat (7) @(posedge clk);
      #1;
      check("pre_reset_sh_en", sh_en, 1);
      reset = 1'b0;
      #1;
      check("midrst_sh_en", sh_en, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      send(12'h001, '{12'h001, 1'b0}, a0);
      drain();

`ifdef SISO_CTRL_PARITY_EN
      // Clean parity, then corrupt the captured bit that lands in out_data[3]
      send(12'h0F1, '{12'h0F1, 1'b0}, a0);
      drain();
      flip_on  = 1'b1;
      flip_idx = WIDTH - 1 - 3;
      send(12'h0F1, '{12'h0F9, 1'b1}, a0);
      drain();
      flip_on  = 1'b0;
`endif

      // DEPTH=1 instance: latency WIDTH+P+1 and exact echo
      in_valid1 = 1'b1;
      in_data1  = 12'h6B2;
      @(negedge clk);
      check("d1_in_ready", in_ready1, 1);
      c = cyc;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid1) begin
         fail("d1_out_valid_timeout");
      end else begin
         check("d1_latency", cyc - c - 1, TOTAL1);
         check("d1_out_data", out_data1, 12'h6B2);
         check("d1_perr", perr1, 0);
      end
      repeat (3) @(negedge clk);

      check("final_queue_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
